cpu_host_loader: RTL and testbench
==================================

Name: cpu_host_loader

Overview:
- Host-side initiator for the cpu external memory ports. It converts a byte-serial command stream into word accesses on the instruction-memory port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext) and the data-memory port (the _2 set).
- Read data is returned as a byte stream.
- The block owns the cpu enable line, so a testbench or UART bridge can load a program, start and stop the cpu, and dump data memory.

Parameters:
- READ_LAT, 1, cycles from the ren cycle until rdata is valid (1..4).
- ADDR_W, 32, width of addr_ext and addr_ext_2.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- rx_data  in  8  command/operand byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data
- cpu_enable  out  1  drives cpu enable
- addr_ext  out  ADDR_W  IMEM address
- wen_ext  out  1  IMEM write enable
- ren_ext  out  1  IMEM read enable
- wdata_ext  out  32  IMEM write word
- rdata_ext  in  32  IMEM read word
- addr_ext_2  out  ADDR_W  DMEM address
- wen_ext_2  out  1  DMEM write enable
- ren_ext_2  out  1  DMEM read enable
- wdata_ext_2  out  32  DMEM write word
- rdata_ext_2  in  32  DMEM read word
- busy  out  1  block is not in IDLE
- cmd_err  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is asynchronous and active-low.
- Reset values: every output is 0 (cpu_enable=0, all enables 0, addresses and wdata 0, tx_valid=0, busy=0, cmd_err=0). rx_ready is 1 once arst_n deasserts.
- Reset mid-operation aborts the transaction immediately. No partial write is issued after reset.
- Handshakes: a byte transfers on a rising edge when valid&&ready. tx_data is held stable while tx_valid&&!tx_ready.
- Command bytes:
  - 0x01 write IMEM, 0x02 read IMEM, 0x03 write DMEM, 0x04 read DMEM.
  - 0x05 start: cpu_enable<=1.
  - 0x06 stop: cpu_enable<=0.
  - Any other value: cmd_err pulses in the cycle after acceptance, and the FSM stays in IDLE.
- Operands:
  - Memory commands are followed by 4 address bytes, LSB first.
  - Writes are then followed by 4 data bytes, LSB first.
  - If ADDR_W<32, the upper address bits are discarded.
- FSM states: IDLE, ADDR (cnt 0..3), DATA (cnt 0..3), WRITE, READ, WAIT, SEND (cnt 0..3).
  - rx_ready=1 only in IDLE, ADDR and DATA.
  - IDLE: 0x05/0x06 take effect on the edge that accepts the byte, and the FSM stays in IDLE. 0x01..0x04 go to ADDR with the port/direction latched.
  - ADDR: after byte 3, writes go to DATA and reads go to READ.
  - DATA: after byte 3, go to WRITE.
  - WRITE: exactly one cycle with the selected wen high and addr/wdata stable. Then IDLE.
  - READ: exactly one cycle with the selected ren high (cycle T). Then WAIT.
  - WAIT: addr is held. The selected rdata is sampled on the rising edge closing cycle T+READ_LAT. Then SEND.
  - SEND: 4 bytes, LSB first. tx_valid=1 throughout. The FSM advances cnt on each handshake, and after byte 3 returns to IDLE.
- Only the selected port's enables assert; the other port's enables stay 0.
- Address and wdata registers keep their last value after a transaction (no clearing).
- Memory commands while cpu_enable=1: operand bytes are still consumed. No wen/ren is issued, cmd_err pulses the cycle after the last operand byte, and reads send no response.
- 0x05 while already running, or 0x06 while stopped: no effect and no error.
- busy=1 in every state except IDLE.
- Back-to-back: a new command byte can be accepted in the cycle after WRITE or after the last SEND handshake.
- rx_valid in non-accepting states is ignored. No bytes are lost, because rx_ready=0 in those states.

Test Plan:
- Reset, then send 01 10 00 00 00 EF BE AD DE -> one cycle later wen_ext=1 for exactly 1 cycle with addr_ext=0x10 and wdata_ext=0xDEADBEEF; wen_ext_2 stays 0; busy returns to 0.
- DMEM write of 0x12345678 at 0x8, then 04 08 00 00 00 with an sram model (READ_LAT=1) -> ren_ext_2 high 1 cycle; tx delivers 78,56,34,12; tx_ready toggled 50% -> bytes are held stable and none is dropped.
- Send 05 -> cpu_enable=1; send 02 00 00 00 00 -> no ren_ext, cmd_err pulses once, no tx bytes; send 06 -> cpu_enable=0.
- Send 0x7F -> cmd_err 1-cycle pulse, state stays IDLE; the next 03 write works normally.
- Pull arst_n low after 2 of 4 data bytes of a write -> all outputs are 0 immediately; after release no wen is issued; a fresh full write succeeds.
- READ_LAT=3: a read returns the word present on rdata at T+3, not at T+1 (the model changes rdata at T+1 and T+3).

Source files
------------

// File: rtl/cpu_host_loader.sv
// Host-side loader: turns a byte-serial command stream into word accesses on the
// cpu IMEM/DMEM external ports, streams read data back, and owns cpu_enable.
module cpu_host_loader #(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [31:0]       wdata_ext_2,
    input  logic [31:0]       rdata_ext_2,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_WAIT, S_SEND
    } state_t;

    localparam logic [7:0] CMD_WR_IMEM = 8'h01;
    localparam logic [7:0] CMD_RD_IMEM = 8'h02;
    localparam logic [7:0] CMD_WR_DMEM = 8'h03;
    localparam logic [7:0] CMD_RD_DMEM = 8'h04;
    localparam logic [7:0] CMD_START   = 8'h05;
    localparam logic [7:0] CMD_STOP    = 8'h06;
    localparam logic [1:0] LAT_LAST    = 2'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        sel_dmem_q, sel_dmem_d;
    logic        is_write_q, is_write_d;
    logic        cpu_enable_q, cpu_enable_d;
    logic [31:0] addr_q, addr_d, addr_2_q, addr_2_d;
    logic [31:0] wdata_q, wdata_d, wdata_2_q, wdata_2_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wen_q, wen_d, ren_q, ren_d;
    logic        wen_2_q, wen_2_d, ren_2_q, ren_2_d;
    logic        cmd_err_q, cmd_err_d;
    logic        accepting, rx_fire, tx_fire;

    // Gated with arst_n so the block never appears ready while held in reset.
    assign accepting = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_ready  = arst_n && accepting;
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_valid  = (state_q == S_SEND);
    assign tx_fire   = tx_valid && tx_ready;
    assign tx_data   = rdata_q[8*cnt_q +: 8];
    assign busy      = (state_q != S_IDLE);

    assign cpu_enable  = cpu_enable_q;
    assign addr_ext    = addr_q[ADDR_W-1:0];
    assign addr_ext_2  = addr_2_q[ADDR_W-1:0];
    assign wdata_ext   = wdata_q;
    assign wdata_ext_2 = wdata_2_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = ren_q;
    assign wen_ext_2   = wen_2_q;
    assign ren_ext_2   = ren_2_q;
    assign cmd_err     = cmd_err_q;

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_dmem_d   = sel_dmem_q;
        is_write_d   = is_write_q;
        cpu_enable_d = cpu_enable_q;
        addr_d       = addr_q;
        addr_2_d     = addr_2_q;
        wdata_d      = wdata_q;
        wdata_2_d    = wdata_2_q;
        rdata_d      = rdata_q;
        wen_d        = 1'b0;
        ren_d        = 1'b0;
        wen_2_d      = 1'b0;
        ren_2_d      = 1'b0;
        cmd_err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (rx_fire) begin
                    unique case (rx_data)
                        CMD_WR_IMEM: begin state_d = S_ADDR; sel_dmem_d = 1'b0; is_write_d = 1'b1; end
                        CMD_RD_IMEM: begin state_d = S_ADDR; sel_dmem_d = 1'b0; is_write_d = 1'b0; end
                        CMD_WR_DMEM: begin state_d = S_ADDR; sel_dmem_d = 1'b1; is_write_d = 1'b1; end
                        CMD_RD_DMEM: begin state_d = S_ADDR; sel_dmem_d = 1'b1; is_write_d = 1'b0; end
                        CMD_START:   cpu_enable_d = 1'b1;
                        CMD_STOP:    cpu_enable_d = 1'b0;
                        default:     cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    if (sel_dmem_q) addr_2_d[8*cnt_q +: 8] = rx_data;
                    else            addr_d[8*cnt_q +: 8]   = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else if (cpu_enable_q) begin
                            // Reads are refused while the cpu owns the memories: no access, no response.
                            state_d   = S_IDLE;
                            cmd_err_d = 1'b1;
                        end else begin
                            state_d = S_READ;
                            ren_d   = !sel_dmem_q;
                            ren_2_d = sel_dmem_q;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    if (sel_dmem_q) wdata_2_d[8*cnt_q +: 8] = rx_data;
                    else            wdata_d[8*cnt_q +: 8]   = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_WRITE;
                        if (cpu_enable_q) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            wen_d   = !sel_dmem_q;
                            wen_2_d = sel_dmem_q;
                        end
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = 2'd0;
            end
            S_WAIT: begin
                // cnt_q counts WAIT cycles; the word is captured on the edge closing cycle T+READ_LAT.
                if (cnt_q == LAT_LAST) begin
                    rdata_d = sel_dmem_q ? rdata_ext_2 : rdata_ext;
                    cnt_d   = 2'd0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            sel_dmem_q   <= 1'b0;
            is_write_q   <= 1'b0;
            cpu_enable_q <= 1'b0;
            addr_q       <= '0;
            addr_2_q     <= '0;
            wdata_q      <= '0;
            wdata_2_q    <= '0;
            rdata_q      <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            wen_2_q      <= 1'b0;
            ren_2_q      <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_dmem_q   <= sel_dmem_d;
            is_write_q   <= is_write_d;
            cpu_enable_q <= cpu_enable_d;
            addr_q       <= addr_d;
            addr_2_q     <= addr_2_d;
            wdata_q      <= wdata_d;
            wdata_2_q    <= wdata_2_d;
            rdata_q      <= rdata_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            wen_2_q      <= wen_2_d;
            ren_2_q      <= ren_2_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Bench for cpu_host_loader: table of command transactions against an sram model
// (READ_LAT=1), plus reset-abort and READ_LAT=3 sampling sequences.
module tb_cpu_host_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;

    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        cpu_enable;
    logic [31:0] addr_ext, addr_ext_2, wdata_ext, wdata_ext_2;
    logic [31:0] rdata_ext, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, cmd_err;

    logic [7:0]  b_rx_data = 8'h00;
    logic        b_rx_valid = 1'b0;
    logic        b_rx_ready;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid;
    logic        b_tx_ready = 1'b0;
    logic        b_cpu_enable;
    logic [31:0] b_addr_ext, b_addr_ext_2, b_wdata_ext, b_wdata_ext_2;
    logic [31:0] b_rdata_ext;
    logic [31:0] b_rdata_ext_2 = 32'h0;
    logic        b_wen_ext, b_ren_ext, b_wen_ext_2, b_ren_ext_2, b_busy, b_cmd_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_host_loader #(.READ_LAT(1), .ADDR_W(32)) u_dut (
        .clk(clk), .arst_n(arst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .cmd_err(cmd_err)
    );

    cpu_host_loader #(.READ_LAT(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .arst_n(arst_n),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .cpu_enable(b_cpu_enable),
        .addr_ext(b_addr_ext), .wen_ext(b_wen_ext), .ren_ext(b_ren_ext),
        .wdata_ext(b_wdata_ext), .rdata_ext(b_rdata_ext),
        .addr_ext_2(b_addr_ext_2), .wen_ext_2(b_wen_ext_2), .ren_ext_2(b_ren_ext_2),
        .wdata_ext_2(b_wdata_ext_2), .rdata_ext_2(b_rdata_ext_2),
        .busy(b_busy), .cmd_err(b_cmd_err)
    );

    // Word-addressed sram models with one cycle of read latency.
    logic [31:0] imem [16];
    logic [31:0] dmem [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            imem[i] = 32'h1000_0000 + i;
            dmem[i] = 32'h2000_0000 + i;
        end
    end

    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[5:2]]   <= wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2[5:2]] <= wdata_ext_2;
        if (ren_ext)   rdata_ext   <= imem[addr_ext[5:2]];
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[5:2]];
    end

    // Slow-memory model: k counts cycles since the ren cycle T, so rdata changes at T+1, T+3 and T+4.
    logic [2:0] b_k;
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n)                     b_k <= 3'd0;
        else if (b_ren_ext)              b_k <= 3'd1;
        else if (b_k != 0 && b_k != 7)   b_k <= b_k + 3'd1;
    end
    always_comb begin
        b_rdata_ext = 32'h0;
        case (b_k)
            3'd1, 3'd2: b_rdata_ext = 32'h1111_1111;
            3'd3:       b_rdata_ext = 32'h3333_CAFE;
            3'd0:       b_rdata_ext = 32'h0;
            default:    b_rdata_ext = 32'h4444_4444;
        endcase
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic        exp_en;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends on a falling edge; the byte transfers on the rising edge in between.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Collects one 4-byte response with tx_ready toggling every cycle, checking hold-while-stalled.
    task automatic recv_word(output logic [31:0] w, output int got);
        int   n = 0;
        bit   stalled = 1'b0;
        logic [7:0] held = 8'h00;
        got = 0;
        w   = 32'h0;
        while (got < 4 && n < 200) begin
            if (stalled) check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held}));
            tx_ready = n[0];
            if (tx_valid && tx_ready) begin
                w[8*got +: 8] = tx_data;
                got++;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            @(negedge clk);
            n++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit          is_mem, is_wr, is_dm;
        logic [31:0] word;
        int          got;
        is_mem = (v.cmd >= 8'h01 && v.cmd <= 8'h04);
        is_wr  = (v.cmd == 8'h01 || v.cmd == 8'h03);
        is_dm  = (v.cmd == 8'h03 || v.cmd == 8'h04);
        send_byte(v.cmd);
        if (!is_mem) begin
            check("ctl_err", 32'(cmd_err), 32'(v.exp_err));
            check("ctl_en", 32'(cpu_enable), 32'(v.exp_en));
            check("ctl_idle", 32'({busy, rx_ready}), 32'b01);
            @(negedge clk);
            check("ctl_err_pulse", 32'(cmd_err), 32'd0);
            return;
        end
        for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
        if (is_wr) begin
            for (int i = 0; i < 4; i++) send_byte(v.data[8*i +: 8]);
            check("wr_err", 32'(cmd_err), 32'(v.exp_err));
            check("wr_wen", 32'({wen_ext, wen_ext_2}), v.exp_err ? 32'b00 : (is_dm ? 32'b01 : 32'b10));
            check("wr_busy", 32'({busy, rx_ready}), 32'b10);
            if (!v.exp_err) begin
                check("wr_addr", is_dm ? addr_ext_2 : addr_ext, v.addr);
                check("wr_data", is_dm ? wdata_ext_2 : wdata_ext, v.data);
            end
            @(negedge clk);
            check("wr_done", 32'({wen_ext, wen_ext_2, busy, cmd_err}), 32'd0);
        end else if (v.exp_err) begin
            check("rd_err", 32'(cmd_err), 32'd1);
            check("rd_ren_off", 32'({ren_ext, ren_ext_2, busy}), 32'd0);
            @(negedge clk);
            check("rd_err_pulse", 32'(cmd_err), 32'd0);
            got = 0;
            tx_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (tx_valid) got++;
                @(negedge clk);
            end
            tx_ready = 1'b0;
            check("rd_no_tx", 32'(got), 32'd0);
        end else begin
            check("rd_ren", 32'({ren_ext, ren_ext_2}), is_dm ? 32'b01 : 32'b10);
            check("rd_addr", is_dm ? addr_ext_2 : addr_ext, v.addr);
            check("rd_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("rd_ren_pulse", 32'({ren_ext, ren_ext_2}), 32'd0);
            recv_word(word, got);
            check("rd_count", 32'(got), 32'd4);
            check("rd_word", word, v.exp_rd);
            check("rd_done", 32'({busy, tx_valid}), 32'd0);
        end
        check("mem_en", 32'(cpu_enable), 32'(v.exp_en));
    endtask

    vec_t vecs [15];

    initial begin
        logic [7:0]  rd_cmd [5];
        logic [31:0] word;
        int          got, lat, n, wen_seen;
        vec_t        v;

        //              cmd    addr   data           err   en    expected read
        vecs[0]  = '{8'h01, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{8'h03, 32'h08, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{8'h04, 32'h08, 32'h0,        1'b0, 1'b0, 32'h12345678};
        vecs[3]  = '{8'h02, 32'h10, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{8'h05, 32'h0,  32'h0,        1'b0, 1'b1, 32'h0};
        vecs[5]  = '{8'h02, 32'h00, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[6]  = '{8'h03, 32'h04, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{8'h05, 32'h0,  32'h0,        1'b0, 1'b1, 32'h0};
        vecs[8]  = '{8'h06, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[9]  = '{8'h06, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[10] = '{8'h7F, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[11] = '{8'h03, 32'h0C, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{8'h04, 32'h04, 32'h0,        1'b0, 1'b0, 32'h20000001};
        vecs[13] = '{8'h04, 32'h0C, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vecs[14] = '{8'h02, 32'h00, 32'h0,        1'b0, 1'b0, 32'h10000000};

        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                              tx_valid, busy, cmd_err, rx_ready}), 32'd0);
        check("rst_addr", addr_ext | addr_ext_2, 32'd0);
        check("rst_wdata", wdata_ext | wdata_ext_2, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check("rst_rx_ready", 32'({rx_ready, busy}), 32'b10);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Reset in the middle of a write's data phase.
        send_byte(8'h03);
        send_byte(8'h14); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        check("abort_busy", 32'(busy), 32'd1);
        arst_n = 1'b0;
        #1;
        check("abort_ctl", 32'({cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                                tx_valid, busy, cmd_err, rx_ready}), 32'd0);
        check("abort_addr", addr_ext | addr_ext_2, 32'd0);
        check("abort_wdata", wdata_ext | wdata_ext_2, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        wen_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wen_ext || wen_ext_2) wen_seen++;
        end
        check("abort_no_wen", 32'(wen_seen), 32'd0);
        v = '{8'h03, 32'h14, 32'h0BADF00D, 1'b0, 1'b0, 32'h0};
        run_vec(v);
        v = '{8'h04, 32'h14, 32'h0,        1'b0, 1'b0, 32'h0BADF00D};
        run_vec(v);

        // READ_LAT=3 instance: IMEM read of address 0.
        rd_cmd     = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        b_tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_rx_data  = rd_cmd[i];
            b_rx_valid = 1'b1;
            check("l3_rx_ready", 32'(b_rx_ready), 32'd1);
            @(negedge clk);
        end
        b_rx_valid = 1'b0;
        check("l3_ren", 32'({b_ren_ext, b_ren_ext_2}), 32'b10);
        got  = 0;
        lat  = 0;
        n    = 0;
        word = 32'h0;
        while (got < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (b_tx_valid) begin
                if (got == 0) lat = n;
                word[8*got +: 8] = b_tx_data;
                got++;
            end
        end
        check("l3_count", 32'(got), 32'd4);
        check("l3_latency", 32'(lat), 32'd4);
        check("l3_word", word, 32'h3333CAFE);
        @(negedge clk);
        check("l3_done", 32'({b_busy, b_tx_valid, b_cmd_err}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
